// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit MIPS-style words and streams
// them into instruction memory, one word per two cycles, with fill tracking.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_class,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              error_q, error_d;
  logic              transfer;
  logic [31:0]       encodedWord;
  logic [ADDR_W:0]   countInc;

  assign in_ready  = (state_q == IDLE) && !clear;
  assign mem_we    = (state_q == WRITE) && !clear;
  assign transfer  = in_valid && in_ready;
  assign countInc  = count_q + (ADDR_W+1)'(1);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign full      = (count_q == CAPACITY);
  assign error     = error_q;

  always_comb begin
    encodedWord = wdata_q;
    case (op_class)
      2'd0:    encodedWord = {6'h00, rs, rt, rd, shamt, funct};
      2'd1:    encodedWord = {6'h08, rs, rt, imm};
      2'd2:    encodedWord = {6'h0d, rs, rt, imm};
      default: encodedWord = wdata_q;
    endcase
  end

  // clear outranks everything and leaves the last encoded word visible
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    error_d = error_q;
    if (clear) begin
      state_d = IDLE;
      addr_d  = '0;
      count_d = '0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            if (op_class == 2'd3) begin
              error_d = 1'b1;
            end else begin
              wdata_d = encodedWord;
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = countInc;
          state_d = (countInc == CAPACITY) ? FULL : IDLE;
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios on a 256-word and a 4-word
// instance sharing one input stream, then randomized traffic against a model.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, inValid;
  logic [1:0]  opClass;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  logic        inReadyA, memWeA, fullA, errorA;
  logic [7:0]  memAddrA;
  logic [31:0] memWdataA;
  logic [8:0]  countA;

  logic        inReadyB, memWeB, fullB, errorB;
  logic [1:0]  memAddrB;
  logic [31:0] memWdataB;
  logic [2:0]  countB;

  int asserts  = 0;
  int failures = 0;

  instr_encoder #(.ADDR_W(8)) dutA (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(inValid), .in_ready(inReadyA),
    .op_class(opClass), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
    .mem_we(memWeA), .mem_addr(memAddrA), .mem_wdata(memWdataA), .count(countA),
    .full(fullA), .error(errorA)
  );

  instr_encoder #(.ADDR_W(2)) dutB (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(inValid), .in_ready(inReadyB),
    .op_class(opClass), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
    .mem_we(memWeB), .mem_addr(memAddrB), .mem_wdata(memWdataB), .count(countB),
    .full(fullB), .error(errorB)
  );

  // reference: instruction formats straight from the ISA field layout
  function automatic logic [31:0] encodeRef(input logic [1:0] oc, input logic [4:0] s, t, d, sh,
                                            input logic [5:0] f, input logic [15:0] i);
    case (oc)
      2'd0:    return {6'h00, s, t, d, sh, f};
      2'd1:    return {6'h08, s, t, i};
      default: return {6'h0d, s, t, i};
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setBundle(input logic [1:0] oc, input logic [4:0] s, t, d, sh,
                           input logic [5:0] f, input logic [15:0] i);
    opClass = oc; rs = s; rt = t; rd = d; shamt = sh; funct = f; imm = i;
  endtask

  task automatic doClear;
    clear = 1'b1; inValid = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; clear = 1'b0; inValid = 1'b0;
    setBundle(2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
    #1;
    asserts++; if (memWeA !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got %0h want 0", memWeA); end
    asserts++; if (memAddrA !== 8'd0) begin failures++; $display("[TB] FAIL reset_addr got %0h want 0", memAddrA); end
    asserts++; if (countA !== 9'd0) begin failures++; $display("[TB] FAIL reset_count got %0h want 0", countA); end
    asserts++; if (memWdataA !== 32'd0) begin failures++; $display("[TB] FAIL reset_wdata got %0h want 0", memWdataA); end
    asserts++; if (errorA !== 1'b0 || fullA !== 1'b0 || fullB !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got err=%0h fullA=%0h fullB=%0h want 0", errorA, fullA, fullB); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    asserts++; if (inReadyA !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got %0h want 1", inReadyA); end
    @(negedge clk);
  endtask

  task automatic test_addi;
    setBundle(2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    #1;
    asserts++; if (memWeA !== 1'b1) begin failures++; $display("[TB] FAIL addi_we got %0h want 1", memWeA); end
    asserts++; if (memAddrA !== 8'd0) begin failures++; $display("[TB] FAIL addi_addr got %0h want 0", memAddrA); end
    asserts++; if (memWdataA !== 32'h20080005) begin failures++; $display("[TB] FAIL addi_wdata got %0h want 20080005", memWdataA); end
    asserts++; if (inReadyA !== 1'b0) begin failures++; $display("[TB] FAIL addi_ready got %0h want 0", inReadyA); end
    tick(); #1;
    asserts++; if (countA !== 9'd1 || memWeA !== 1'b0) begin failures++; $display("[TB] FAIL addi_count got count=%0h we=%0h want 1/0", countA, memWeA); end
  endtask

  task automatic test_back_to_back;
    doClear();
    setBundle(2'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0);
    inValid = 1'b1;
    tick();
    setBundle(2'd2, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 16'h00FF);
    #1;
    asserts++; if (memWeA !== 1'b1 || memAddrA !== 8'd0 || memWdataA !== 32'h012A4020) begin failures++; $display("[TB] FAIL b2b_first got we=%0h addr=%0h data=%0h want 1/0/012a4020", memWeA, memAddrA, memWdataA); end
    asserts++; if (inReadyA !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready1 got %0h want 0", inReadyA); end
    tick(); #1;
    asserts++; if (inReadyA !== 1'b1 || memWeA !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got ready=%0h we=%0h want 1/0", inReadyA, memWeA); end
    tick();
    inValid = 1'b0;
    #1;
    asserts++; if (memWeA !== 1'b1 || memAddrA !== 8'd1 || memWdataA !== 32'h340900FF) begin failures++; $display("[TB] FAIL b2b_second got we=%0h addr=%0h data=%0h want 1/1/340900ff", memWeA, memAddrA, memWdataA); end
    asserts++; if (inReadyA !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready2 got %0h want 0", inReadyA); end
    tick(); #1;
    asserts++; if (countA !== 9'd2) begin failures++; $display("[TB] FAIL b2b_count got %0h want 2", countA); end
  endtask

  task automatic test_illegal;
    doClear();
    setBundle(2'd3, 5'd1, 5'd2, 5'd3, 5'd4, 6'h3f, 16'hbeef);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    #1;
    asserts++; if (memWeA !== 1'b0 || errorA !== 1'b1) begin failures++; $display("[TB] FAIL ill_flags got we=%0h err=%0h want 0/1", memWeA, errorA); end
    asserts++; if (countA !== 9'd0 || memWdataA !== 32'h340900FF) begin failures++; $display("[TB] FAIL ill_hold got count=%0h data=%0h want 0/340900ff", countA, memWdataA); end
    setBundle(2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    #1;
    asserts++; if (memWeA !== 1'b1 || memAddrA !== 8'd0 || memWdataA !== 32'h20080005) begin failures++; $display("[TB] FAIL ill_next got we=%0h addr=%0h data=%0h want 1/0/20080005", memWeA, memAddrA, memWdataA); end
    tick(); #1;
    asserts++; if (errorA !== 1'b1 || countA !== 9'd1) begin failures++; $display("[TB] FAIL ill_sticky got err=%0h count=%0h want 1/1", errorA, countA); end
  endtask

  task automatic test_full;
    doClear();
    for (int i = 0; i < 4; i++) begin
      setBundle(2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i));
      inValid = 1'b1;
      tick(); #1;
      asserts++; if (memWeB !== 1'b1 || memAddrB !== 2'(i)) begin failures++; $display("[TB] FAIL full_write%0d got we=%0h addr=%0h want 1/%0d", i, memWeB, memAddrB, i); end
      tick();
    end
    #1;
    asserts++; if (countB !== 3'd4 || fullB !== 1'b1) begin failures++; $display("[TB] FAIL full_flag got count=%0h full=%0h want 4/1", countB, fullB); end
    asserts++; if (memAddrB !== 2'd0 || inReadyB !== 1'b0) begin failures++; $display("[TB] FAIL full_wrap got addr=%0h ready=%0h want 0/0", memAddrB, inReadyB); end
    asserts++; if (fullA !== 1'b0 || countA !== 9'd4) begin failures++; $display("[TB] FAIL full_big got full=%0h count=%0h want 0/4", fullA, countA); end
    tick(); #1;
    asserts++; if (memWeB !== 1'b0 || countB !== 3'd4) begin failures++; $display("[TB] FAIL full_ignore got we=%0h count=%0h want 0/4", memWeB, countB); end
    doClear();
    #1;
    asserts++; if (countB !== 3'd0 || fullB !== 1'b0 || inReadyB !== 1'b1) begin failures++; $display("[TB] FAIL full_clear got count=%0h full=%0h ready=%0h want 0/0/1", countB, fullB, inReadyB); end
  endtask

  task automatic test_clear_write;
    doClear();
    setBundle(2'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    clear = 1'b1;
    #1;
    asserts++; if (memWeA !== 1'b0) begin failures++; $display("[TB] FAIL clrw_we got %0h want 0", memWeA); end
    tick();
    clear = 1'b0;
    #1;
    asserts++; if (countA !== 9'd0 || memWeA !== 1'b0) begin failures++; $display("[TB] FAIL clrw_count got count=%0h we=%0h want 0/0", countA, memWeA); end
    clear = 1'b1; inValid = 1'b1;
    #1;
    asserts++; if (inReadyA !== 1'b0) begin failures++; $display("[TB] FAIL clri_ready got %0h want 0", inReadyA); end
    tick();
    clear = 1'b0; inValid = 1'b0;
    #1;
    asserts++; if (memWeA !== 1'b0 || inReadyA !== 1'b1) begin failures++; $display("[TB] FAIL clri_notransfer got we=%0h ready=%0h want 0/1", memWeA, inReadyA); end
  endtask

  task automatic test_reset_mid_write;
    doClear();
    setBundle(2'd1, 5'd7, 5'd7, 5'd0, 5'd0, 6'd0, 16'hffff);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    #1;
    asserts++; if (memWeA !== 1'b1) begin failures++; $display("[TB] FAIL rmw_pre got %0h want 1", memWeA); end
    #1 reset = 1'b0;
    #1;
    asserts++; if (memWeA !== 1'b0 || memAddrA !== 8'd0 || countA !== 9'd0) begin failures++; $display("[TB] FAIL rmw_async got we=%0h addr=%0h count=%0h want 0/0/0", memWeA, memAddrA, countA); end
    asserts++; if (memWdataA !== 32'd0 || errorA !== 1'b0 || fullA !== 1'b0) begin failures++; $display("[TB] FAIL rmw_vals got data=%0h err=%0h full=%0h want 0/0/0", memWdataA, errorA, fullA); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    asserts++; if (inReadyA !== 1'b1) begin failures++; $display("[TB] FAIL rmw_ready got %0h want 1", inReadyA); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int          cap[2];
    bit          busy[2];
    int          mAddr[2], mCount[2];
    bit          mErr[2];
    logic [31:0] mWdata[2];
    int          actReady, actWe, actAddr, actCount, actFull, actErr;
    logic [31:0] actWdata;
    cap = '{256, 4};
    reset = 1'b0; clear = 1'b0; inValid = 1'b0;
    #2 reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; mAddr[k] = 0; mCount[k] = 0; mErr[k] = 0; mWdata[k] = '0;
    end
    @(negedge clk);
    for (int c = 0; c < 600; c++) begin
      clear   = ($urandom_range(0, 24) == 0);
      inValid = ($urandom_range(0, 2) != 0);
      setBundle(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 6'($urandom), 16'($urandom));
      #1;
      for (int k = 0; k < 2; k++) begin
        actReady = (k == 0) ? int'(inReadyA)  : int'(inReadyB);
        actWe    = (k == 0) ? int'(memWeA)    : int'(memWeB);
        actAddr  = (k == 0) ? int'(memAddrA)  : int'(memAddrB);
        actCount = (k == 0) ? int'(countA)    : int'(countB);
        actFull  = (k == 0) ? int'(fullA)     : int'(fullB);
        actErr   = (k == 0) ? int'(errorA)    : int'(errorB);
        actWdata = (k == 0) ? memWdataA       : memWdataB;
        asserts++; if (actReady !== int'(!busy[k] && mCount[k] != cap[k] && !clear)) begin failures++; $display("[TB] FAIL rnd_ready c=%0d k=%0d got %0d", c, k, actReady); end
        asserts++; if (actWe !== int'(busy[k] && !clear)) begin failures++; $display("[TB] FAIL rnd_we c=%0d k=%0d got %0d", c, k, actWe); end
        asserts++; if (actAddr !== mAddr[k]) begin failures++; $display("[TB] FAIL rnd_addr c=%0d k=%0d got %0d want %0d", c, k, actAddr, mAddr[k]); end
        asserts++; if (actCount !== mCount[k]) begin failures++; $display("[TB] FAIL rnd_count c=%0d k=%0d got %0d want %0d", c, k, actCount, mCount[k]); end
        asserts++; if (actFull !== int'(mCount[k] == cap[k])) begin failures++; $display("[TB] FAIL rnd_full c=%0d k=%0d got %0d", c, k, actFull); end
        asserts++; if (actErr !== int'(mErr[k])) begin failures++; $display("[TB] FAIL rnd_error c=%0d k=%0d got %0d want %0d", c, k, actErr, mErr[k]); end
        asserts++; if (actWdata !== mWdata[k]) begin failures++; $display("[TB] FAIL rnd_wdata c=%0d k=%0d got %0h want %0h", c, k, actWdata, mWdata[k]); end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (clear) begin
          busy[k] = 0; mAddr[k] = 0; mCount[k] = 0; mErr[k] = 0;
        end else if (busy[k]) begin
          busy[k] = 0;
          mAddr[k] = (mAddr[k] + 1) % cap[k];
          mCount[k] = mCount[k] + 1;
        end else if (inValid && mCount[k] != cap[k]) begin
          if (opClass == 2'd3) mErr[k] = 1;
          else begin
            mWdata[k] = encodeRef(opClass, rs, rt, rd, shamt, funct, imm);
            busy[k] = 1;
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_illegal();
    test_full();
    test_clear_write();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 8, meaning instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 clear  input  1  synchronous: restart load at address 0, clear count and error.
REQ-005 in_valid  input  1  field bundle valid.
REQ-006 in_ready  output  1  block can accept a bundle this cycle.
REQ-007 op_class  input  2  0=R-type, 1=ADDI, 2=ORI, 3=illegal.
REQ-008 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-009 funct  input  6  R-type function field.
REQ-010 imm  input  16  I-type immediate.
REQ-011 mem_we  output  1  instruction-memory write strobe.
REQ-012 mem_addr  output  ADDR_W  word address of current write.
REQ-013 mem_wdata  output  32  encoded instruction word.
REQ-014 count  output  ADDR_W+1  number of words written since reset/clear.
REQ-015 full  output  1  count equals 2^ADDR_W.
REQ-016 error  output  1  sticky: an illegal op_class bundle was consumed.

Function
REQ-017 FSM states: IDLE, WRITE, FULL.
REQ-018 Handshake: a bundle transfers on a rising edge where in_valid=1 and in_ready=1; in_ready=1 only in IDLE with clear=0.
REQ-019 Encoding on transfer, registered into mem_wdata: R-type {6'h00,rs,rt,rd,shamt,funct}; ADDI {6'h08,rs,rt,imm}; ORI {6'h0d,rs,rt,imm}.
REQ-020 IDLE -> WRITE on transfer of a legal class; IDLE stays IDLE otherwise.
REQ-021 Illegal class (3): bundle consumed, no write, mem_wdata unchanged, error set to 1, state remains IDLE.
REQ-022 WRITE lasts exactly one cycle: mem_we=1, mem_addr = current address; on exit, address and count increment by 1.
REQ-023 mem_we is 0 in every state except WRITE; latency from transfer edge to mem_we=1 is one cycle; throughput one word per two cycles.
REQ-024 WRITE -> FULL when the incremented count equals 2^ADDR_W, else WRITE -> IDLE.
REQ-025 Address wraps to 0 after the last location; in FULL, in_ready=0, no writes, state held until clear or reset.
REQ-026 full = 1 exactly when count = 2^ADDR_W.
REQ-027 clear (any state): next state IDLE, address=0, count=0, error=0, mem_wdata unchanged; clear has priority over in_valid (no transfer that cycle).
REQ-028 clear asserted during WRITE: mem_we forced 0 that cycle, the word is not written, count not incremented.
REQ-029 error remains 1 through later legal transfers until clear or reset.
REQ-030 Input fields are sampled only on transfer edges; changes at other times have no effect.

Reset
REQ-031 reset=0 asynchronously forces state IDLE, mem_addr=0, count=0, mem_wdata=0, error=0, mem_we=0, full=0.
REQ-032 reset asserted mid-WRITE suppresses the write immediately; after release, in_ready=1 on the first rising edge.

Verification
REQ-033 ADDI rs=0 rt=8 imm=0x0005 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x20080005; then count=1.
REQ-034 R-type rs=9 rt=10 rd=8 shamt=0 funct=0x20, then ORI rs=0 rt=9 imm=0x00FF with in_valid held -> writes 0x012A4020 at addr 0, 0x340900FF at addr 1, in_ready low during each WRITE cycle.
REQ-035 op_class=3 transfer -> no mem_we, error=1, count unchanged; subsequent ADDI still written at the next address, error stays 1.
REQ-036 ADDR_W=2, four legal transfers -> count=4, full=1, mem_addr=0, in_ready=0; fifth in_valid ignored; clear -> count=0, full=0, in_ready=1.
REQ-037 clear asserted in the WRITE cycle -> mem_we=0, count stays 0; clear with in_valid in IDLE -> no transfer.
REQ-038 reset pulsed low mid-WRITE -> mem_we drops asynchronously, all outputs at REQ-031 values.
